// File: rtl/dm_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per master.
// The requester drives req/we/addr/wdata and holds them until ack; the
// arbiter returns a one-cycle ack and the read data.
interface dm_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the word-addressed
// data memory. Port A is the CPU MEM stage, port B a secondary master.
// Each grant runs IDLE -> ACC (memory access) -> RSP (ack), so at most one
// transaction completes every three cycles. The granted request is latched at
// grant time, so the memory strobes depend only on state and latched data.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   a,
  dm_arbiter_if.slave   b,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  output logic          dm_re,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          sel_r;        // 0 = port A, 1 = port B
  logic          last_r;       // winner of the previous grant
  logic          grant_s;
  logic          grant_sel_s;
  logic          txn_we_r;
  logic [AW-1:0] txn_addr_r;
  logic [DW-1:0] txn_wdata_r;
  logic          a_ack_r;
  logic          b_ack_r;
  logic [DW-1:0] a_rdata_r;
  logic [DW-1:0] b_rdata_r;

  // Arbitration and next state; requests are only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_sel_s = sel_r;
    case (state_r)
      IDLE: begin
        if (a.req && b.req) begin
          grant_s     = 1'b1;
          grant_sel_s = ~last_r;
        end else if (a.req) begin
          grant_s     = 1'b1;
          grant_sel_s = 1'b0;
        end else if (b.req) begin
          grant_s     = 1'b1;
          grant_sel_s = 1'b1;
        end else begin
          grant_s     = 1'b0;
          grant_sel_s = sel_r;
        end
        if (grant_s) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC:     state_nxt_s = RSP;
      RSP:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the winner and its transaction at grant so later req changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r       <= 1'b0;
      txn_we_r    <= 1'b0;
      txn_addr_r  <= {AW{1'b0}};
      txn_wdata_r <= {DW{1'b0}};
    end else if (grant_s) begin
      sel_r       <= grant_sel_s;
      txn_we_r    <= grant_sel_s ? b.we    : a.we;
      txn_addr_r  <= grant_sel_s ? b.addr  : a.addr;
      txn_wdata_r <= grant_sel_s ? b.wdata : a.wdata;
    end
  end

  // Remember the last served port; reset favours A on the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (state_r == RSP) begin
      last_r <= sel_r;
    end
  end

  // Ack flops: set during ACC so the pulse appears exactly in RSP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
    end else begin
      a_ack_r <= (state_r == ACC) && !sel_r;
      b_ack_r <= (state_r == ACC) &&  sel_r;
    end
  end

  // Capture read data into the selected port only; writes leave rdata alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_r <= {DW{1'b0}};
      b_rdata_r <= {DW{1'b0}};
    end else if ((state_r == ACC) && !txn_we_r) begin
      if (sel_r) begin
        b_rdata_r <= dm_dout;
      end else begin
        a_rdata_r <= dm_dout;
      end
    end
  end

  // Memory strobes decoded from state and latched transaction only
  always_comb begin
    dm_addr = {AW{1'b0}};
    dm_din  = {DW{1'b0}};
    dm_we   = 1'b0;
    dm_re   = 1'b0;
    if (state_r == ACC) begin
      dm_addr = txn_addr_r;
      dm_din  = txn_wdata_r;
      dm_we   = txn_we_r;
      dm_re   = ~txn_we_r;
    end else begin
      dm_addr = {AW{1'b0}};
      dm_din  = {DW{1'b0}};
      dm_we   = 1'b0;
      dm_re   = 1'b0;
    end
  end

  assign busy    = (state_r != IDLE);
  assign a.ack   = a_ack_r;
  assign b.ack   = b_ack_r;
  assign a.rdata = a_rdata_r;
  assign b.rdata = b_rdata_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a behavioural memory answers the dm_* bus, requester
// tasks issue transactions and push them into per-port queues, and a monitor
// pops on every ack and checks against an abstract memory model applied in
// completion order, plus round-robin fairness and ack spacing.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            iss;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic [DW-1:0] dm_dout;
  logic          dm_we;
  logic          dm_re;
  logic          busy;

  dm_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  dm_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a_if),
    .b       (b_if),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_re   (dm_re),
    .dm_dout (dm_dout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  txn_t          qa[$];
  txn_t          qb[$];
  int            ack_port[$];
  int            ack_cyc[$];
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] last_rd [2];
  int            last_p;
  int            last_c;

  // cycle index, advanced on the active edge
  always @(posedge clk) cyc <= cyc + 1;

  // physical memory: combinational read, write on rising edge
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h001] = 32'h00000055;
    forever begin
      @(posedge clk);
      if (dm_we) mem[dm_addr] = dm_din;
    end
  end
  assign dm_dout = dm_re ? mem[dm_addr] : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (p == 0) begin
      a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = wd;
    end else begin
      b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = wd;
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    txn_t t;
    t.we = w; t.addr = ad; t.wd = wd; t.iss = cyc;
    drive(p, 1'b1, w, ad, wd);
    if (p == 0) qa.push_back(t);
    else qb.push_back(t);
  endtask

  // issue a request and wait (bounded) for its ack; req stays high afterwards
  task automatic port_txn(input int p, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    logic got;
    issue(p, w, ad, wd);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? a_if.ack : b_if.ack;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout port %0d: got no ack, expected ack within 20 cycles", p);
    end
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom % 4 == 0) return 10'($urandom_range(0, 1023));
    else return 10'($urandom_range(0, 15));
  endfunction

  task automatic port_rand(input int p, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      port_txn(p, 1'($urandom % 2), raddr(), $urandom);
      if (gaps && ($urandom % 3 == 0)) begin
        drive(p, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drive(p, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic on_ack(input int p);
    int            o;
    int            v;
    txn_t          t;
    logic [DW-1:0] rd_p;
    logic [DW-1:0] rd_o;
    o    = 1 - p;
    rd_p = (p == 0) ? a_if.rdata : b_if.rdata;
    rd_o = (p == 0) ? b_if.rdata : a_if.rdata;
    ack_port.push_back(p);
    ack_cyc.push_back(cyc);
    chk("ack_spacing_ge3", 32'(cyc - last_c >= 3), 32'd1);
    if ((p == 0 && qa.size() == 0) || (p == 1 && qb.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_ack port %0d: got ack, expected none (no request outstanding)", p);
    end else begin
      t = (p == 0) ? qa.pop_front() : qb.pop_front();
      v = 0;
      if (last_p == p) begin
        if (o == 0 && qa.size() > 0 && qa[0].iss <= last_c + 1) v = 1;
        if (o == 1 && qb.size() > 0 && qb[0].iss <= last_c + 1) v = 1;
      end
      chk("fair_grant", 32'(v), 32'd0);
      if (t.we) begin
        ref_mem[t.addr] = t.wd;
        chk("mem_write", mem[t.addr], t.wd);
        chk("rdata_hold_on_write", rd_p, last_rd[p]);
      end else begin
        last_rd[p] = ref_mem[t.addr];
        chk("read_data", rd_p, last_rd[p]);
      end
      chk("other_rdata_untouched", rd_o, last_rd[o]);
    end
    last_p = p;
    last_c = cyc;
  endtask

  // monitor: pop and check whenever an ack is presented
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[10'h010] = 32'hDEADBEEF;
    ref_mem[10'h001] = 32'h00000055;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    last_p = 1;
    last_c = -100;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        last_p = 1;
        last_c = -100;
      end else if (a_if.ack || b_if.ack) begin
        chk("no_double_ack", 32'(a_if.ack && b_if.ack), 32'd0);
        if (a_if.ack) on_ack(0);
        else on_ack(1);
      end
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // stimulus
  initial begin
    int nwe;
    int seen;
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_ack", 32'(a_if.ack), 32'd0);
    chk("rst_b_ack", 32'(b_if.ack), 32'd0);
    chk("rst_a_rdata", a_if.rdata, 32'h0);
    chk("rst_b_rdata", b_if.rdata, 32'h0);
    chk("rst_dm_addr", 32'(dm_addr), 32'h0);
    chk("rst_dm_din", dm_din, 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // read latency: ACC in t1, ack in t2, idle in t3
    issue(0, 1'b0, 10'h010, 32'h0);
    @(negedge clk);
    chk("rd_t1_dm_re", 32'(dm_re), 32'd1);
    chk("rd_t1_dm_we", 32'(dm_we), 32'd0);
    chk("rd_t1_dm_addr", 32'(dm_addr), 32'h010);
    chk("rd_t1_busy", 32'(busy), 32'd1);
    chk("rd_t1_no_ack", 32'(a_if.ack), 32'd0);
    @(negedge clk);
    chk("rd_t2_a_ack", 32'(a_if.ack), 32'd1);
    chk("rd_t2_a_rdata", a_if.rdata, 32'hDEADBEEF);
    chk("rd_t2_dm_re_off", 32'(dm_re), 32'd0);
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk("rd_t3_busy", 32'(busy), 32'd0);
    chk("rd_t3_ack_gone", 32'(a_if.ack), 32'd0);

    // B writes 0x3FF, then A reads it back
    issue(1, 1'b1, 10'h3FF, 32'h12345678);
    nwe = 0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (dm_we) nwe++;
      if (j == 1) begin
        chk("wr_dm_addr", 32'(dm_addr), 32'h3FF);
        chk("wr_dm_din", dm_din, 32'h12345678);
      end
      if (j == 2) begin
        chk("wr_b_ack_t2", 32'(b_if.ack), 32'd1);
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
      end
    end
    chk("wr_dm_we_one_cycle", 32'(nwe), 32'd1);
    port_txn(0, 1'b0, 10'h3FF, 32'h0);
    chk("rd_back_a_rdata", a_if.rdata, 32'h12345678);
    chk("rd_back_b_rdata", b_if.rdata, 32'h0);
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);

    // write does not disturb rdata
    port_txn(0, 1'b0, 10'h001, 32'h0);
    chk("iso_first_read", a_if.rdata, 32'h00000055);
    port_txn(0, 1'b1, 10'h001, 32'h000000AA);
    chk("iso_rdata_on_write_ack", a_if.rdata, 32'h00000055);
    port_txn(0, 1'b0, 10'h001, 32'h0);
    chk("iso_reread", a_if.rdata, 32'h000000AA);
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);

    // B drops req during ACC: ack still issued, no re-grant
    issue(1, 1'b0, 10'h010, 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk("drop_b_ack", 32'(b_if.ack), 32'd1);
    chk("drop_b_rdata", b_if.rdata, 32'hDEADBEEF);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || b_if.ack) seen = 1;
    end
    chk("drop_no_regrant", 32'(seen), 32'd0);

    // reset in ACC of an A write: strobe falls at once, no ack, no write
    issue(0, 1'b1, 10'h020, 32'hFFFFFFFF);
    void'(qa.pop_back());
    @(negedge clk);
    chk("rstacc_dm_we_before", 32'(dm_we), 32'd1);
    #2;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    chk("rstacc_dm_we_now", 32'(dm_we), 32'd0);
    chk("rstacc_busy", 32'(busy), 32'd0);
    chk("rstacc_no_ack", 32'(a_if.ack), 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    ack_port.delete();
    ack_cyc.delete();

    // contention from reset: alternating acks every 3 cycles, A first
    fork
      port_rand(0, 6, 1'b0);
      port_rand(1, 6, 1'b0);
      begin
        repeat (2) @(negedge clk);
        chk("rstacc_no_write", mem[10'h020], 32'h0);
        rst = 1'b0;
      end
    join
    chk("cont_ack_count", 32'(ack_port.size()), 32'd12);
    for (int i = 0; i < ack_port.size(); i++) begin
      chk("cont_ack_order", 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) chk("cont_ack_period", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    @(negedge clk);

    // randomized traffic on both ports
    fork
      port_rand(0, 40, 1'b1);
      port_rand(1, 40, 1'b1);
    join
    repeat (5) @(negedge clk);
    chk("end_qa_empty", 32'(qa.size()), 32'd0);
    chk("end_qb_empty", 32'(qb.size()), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
